// File: rtl/shift_reg_univ.sv
// Universal shift register: parallel load, five single-step shift/rotate modes,
// serial in/out, and a counted burst engine that applies one step per clock.
module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    input  logic             shift,
    input  logic [2:0]       op,
    input  logic             ser_in,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] d_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done,
    output logic             state_dbg
);

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_BURST = 1'b1;

    localparam logic [2:0] OP_SHL = 3'b000;
    localparam logic [2:0] OP_SHR = 3'b001;
    localparam logic [2:0] OP_ROL = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ASR = 3'b100;

    logic             state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] r;
    logic             so;

    logic [2:0]       op_sel;
    logic [WIDTH-1:0] step_r;
    logic             step_so;

    // A burst runs with the op latched at start; single shifts use the live op.
    assign op_sel = (state == S_BURST) ? op_q : op;

    always_comb begin
        step_r  = r;
        step_so = so;
        case (op_sel)
            OP_SHL: begin step_r = {r[WIDTH-2:0], ser_in};   step_so = r[WIDTH-1]; end
            OP_SHR: begin step_r = {ser_in, r[WIDTH-1:1]};   step_so = r[0];       end
            OP_ROL: begin step_r = {r[WIDTH-2:0], r[WIDTH-1]}; step_so = r[WIDTH-1]; end
            OP_ROR: begin step_r = {r[0], r[WIDTH-1:1]};     step_so = r[0];       end
            OP_ASR: begin step_r = {r[WIDTH-1], r[WIDTH-1:1]}; step_so = r[0];     end
            default: begin step_r = r; step_so = so; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            r     <= '0;
            so    <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load) begin
                        r <= d_in;
                    end else if (start) begin
                        // A zero-length burst completes immediately without entering BURST.
                        if (amount != '0) begin
                            op_q  <= op;
                            cnt   <= amount;
                            state <= S_BURST;
                        end else begin
                            done <= 1'b1;
                        end
                    end else if (shift) begin
                        r  <= step_r;
                        so <= step_so;
                    end
                end
                default: begin
                    r   <= step_r;
                    so  <= step_so;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign d_out     = r;
    assign ser_out   = so;
    assign busy      = (state == S_BURST);
    assign state_dbg = state;

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register with serial I/O and a multi-step burst engine. It supports parallel load, single-step shifts and rotates in five modes, and a counted burst that applies one step per clock for a programmed number of steps. It serves as the general-purpose shift/serialiser primitive in the datapath and replaces the fixed 8-bit left-shift register in new designs.

## Interface
- WIDTH, 8: register width in bits, ≥2.
- CNT_W, 4: width of the burst amount field; max burst = 2^CNT_W−1 steps.

- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- load  input  1  parallel load of d_in.
- d_in  input  WIDTH  parallel load data.
- shift  input  1  perform one step of mode op this cycle.
- op  input  3  step mode: 000 SHL, 001 SHR, 010 ROL, 011 ROR, 100 ASR, 101–111 reserved (no-op).
- ser_in  input  1  serial fill bit for SHL (enters bit 0) and SHR (enters bit WIDTH−1).
- start  input  1  begin burst of `amount` steps using op.
- amount  input  CNT_W  burst step count, sampled on start.
- d_out  output  WIDTH  register contents.
- ser_out  output  1  last bit shifted or rotated out.
- busy  output  1  burst in progress.
- done  output  1  single-cycle burst-complete pulse.

## Operation
- States: IDLE, BURST.
- Step definitions, with r as the current register:
  - SHL: {r[W−2:0], ser_in}; ser_out ← r[W−1].
  - SHR: {ser_in, r[W−1:1]}; ser_out ← r[0].
  - ROL: {r[W−2:0], r[W−1]}; ser_out ← r[W−1].
  - ROR: {r[0], r[W−1:1]}; ser_out ← r[0].
  - ASR: {r[W−1], r[W−1:1]}; ser_out ← r[0].
  - Reserved op: register and ser_out unchanged.
- IDLE priority: rst > load > start > shift > hold.
  - load: r ← d_in. ser_out unchanged.
  - start with amount ≥1: latch op into op_q and amount into cnt, go to BURST. Register unchanged this edge.
  - start with amount = 0: stay in IDLE, register unchanged, done=1 for the next cycle.
  - shift: one step with the live op.
- BURST behaviour:
  - Each edge performs one step with op_q, using ser_in sampled live, and decrements cnt.
  - When cnt goes 1→0, return to IDLE and assert done for one cycle.
- While in BURST, load, shift and start are ignored. A new start is only accepted in IDLE, including the cycle in which done is high.
- Reserved op latched on start: the burst still runs for `amount` cycles and completes with done, but the register is unchanged.

## Timing
- Reset (rst=1 at an edge): d_out=0, ser_out=0, busy=0, done=0, state IDLE, cnt=0. Reset overrides everything, including mid-burst; the burst is abandoned with no done pulse.
- load or shift at edge N: new value visible on d_out after edge N, so latency is 1 cycle.
- Burst with start at edge N and amount=k≥1:
  - busy=1 from after edge N to after edge N+k.
  - Steps occur at edges N+1 … N+k.
  - busy=0 and done=1 after edge N+k; done=0 after edge N+k+1.
  - Total k+1 cycles from start to done.
- done is driven from a register and is never combinational from start.
- ser_out holds its value between steps.

## Test plan
- Reset mid-burst: load 0xA5, start ROL amount=5, assert rst after 2 steps → d_out=0x00, ser_out=0, busy=0, done never pulses.
- Load/shift, WIDTH=8: load 0x81, shift op=SHL ser_in=1 → d_out=0x03, ser_out=1; then op=SHR ser_in=0 → d_out=0x01, ser_out=1.
- Rotates and ASR: load 0x96, op=ROR → 0x4B, ser_out=0; op=ROL → 0x96, ser_out=0; op=ASR → 0xCB, then ASR again → 0xE5, ser_out=1.
- Burst timing: load 0x01, start op=ROL amount=3 at edge N → busy high edges N..N+2 (after), d_out=0x08 and done=1 only in the cycle after edge N+3; load and shift pulsed during the burst have no effect.
- Burst boundaries:
  - amount=0 → done=1 for 1 cycle, busy never high, d_out unchanged.
  - amount=15 with op=ROL on 0x01 → d_out=0x80 after 15 steps.
  - start reasserted in the done cycle → accepted.
- Priority: load and start asserted together in IDLE → d_in loaded, no burst. start and shift together → burst starts, no immediate step. Reserved op 110 with shift → no change.
